// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage and its neighbouring pipeline registers.
package mem_access_stage_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_DONE = 1'b1
   } mem_state_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   // Control bundle carried through ID/EX, EX/MEM and MEM/WB.
   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_read;
      logic mem_write;
   } pipe_ctrl_t;

   function automatic logic is_mem_op(input pipe_ctrl_t c);
      return c.mem_read | c.mem_write;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for a pending data-memory request; tc flags the last permitted cycle.
module mem_timeout_ctr #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register plus the data-memory access FSM; stalls upstream while a request is open.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EX_RegWrite_in,
   input  logic        EX_MemtoReg_in,
   input  logic        EX_MemRead_in,
   input  logic        EX_MemWrite_in,
   input  logic [31:0] EX_alu_out_in,
   input  logic [31:0] EX_wd_in,
   input  logic [4:0]  EX_rfile_wn_in,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        MEM_RegWrite_out,
   output logic        MEM_MemtoReg_out,
   output logic [31:0] MEM_RD_out,
   output logic [31:0] MEM_alu_out_out,
   output logic [4:0]  MEM_rfile_wn_out,
   output logic        mem_err
);

   pipe_ctrl_t  ctrl_q, ctrl_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] wd_q, wd_d;
   logic [4:0]  wn_q, wn_d;
   mem_state_e  state_q, state_d;
   logic [31:0] rd_q, rd_d;
   logic        err_q, err_d;

   logic busy;
   logic tc;
   logic ack_hit;
   logic timeout_hit;
   logic is_store;

   assign busy        = (state_q == ST_IDLE) && is_mem_op(ctrl_q);
   assign ack_hit     = busy & dmem_ack;
   assign timeout_hit = busy & ~dmem_ack & tc;
   // MemRead together with MemWrite is treated as a store.
   assign is_store    = ctrl_q.mem_write;

   mem_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout_ctr (
      .clk(clk),
      .rst(rst),
      .clr(~busy | dmem_ack | tc),
      .en (busy & ~dmem_ack),
      .tc (tc)
   );

   always_comb begin
      ctrl_d  = ctrl_q;
      alu_d   = alu_q;
      wd_d    = wd_q;
      wn_d    = wn_q;
      state_d = state_q;
      rd_d    = rd_q;
      err_d   = err_q;

      if (!busy) begin
         ctrl_d.reg_write  = EX_RegWrite_in;
         ctrl_d.mem_to_reg = EX_MemtoReg_in;
         ctrl_d.mem_read   = EX_MemRead_in;
         ctrl_d.mem_write  = EX_MemWrite_in;
         alu_d             = EX_alu_out_in;
         wd_d              = EX_wd_in;
         wn_d              = EX_rfile_wn_in;
      end

      case (state_q)
         ST_IDLE: begin
            if (ack_hit || timeout_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (ack_hit && !is_store) begin
         rd_d = dmem_rdata;
      end
      if (timeout_hit) begin
         if (!is_store) begin
            rd_d = ERR_DATA;
         end
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q  <= '0;
         alu_q   <= '0;
         wd_q    <= '0;
         wn_q    <= '0;
         state_q <= ST_IDLE;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         alu_q   <= alu_d;
         wd_q    <= wd_d;
         wn_q    <= wn_d;
         state_q <= state_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
      end
   end

   assign stall            = busy;
   assign dmem_req         = busy;
   assign dmem_we          = busy & is_store;
   assign dmem_addr        = alu_q;
   assign dmem_wdata       = wd_q;
   // Bubble into MEM/WB while the access is outstanding.
   assign MEM_RegWrite_out = ctrl_q.reg_write & ~busy;
   assign MEM_MemtoReg_out = ctrl_q.mem_to_reg & ~busy;
   assign MEM_RD_out       = rd_q;
   assign MEM_alu_out_out  = alu_q;
   assign MEM_rfile_wn_out = wn_q;
   assign mem_err          = err_q;

endmodule
